// File: rtl/rgmii_link_pkg.sv
// rtl/rgmii_link_pkg.sv - shared constants for the RGMII link/speed controller
package rgmii_link_pkg;

    typedef enum logic [1:0] {
        SPEED_10M   = 2'b00,
        SPEED_100M  = 2'b01,
        SPEED_1000M = 2'b10,
        SPEED_RSVD  = 2'b11
    } speed_e;

    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;

    localparam logic [5:0] MDIO_LAST_BIT   = 6'd63;
    localparam logic [5:0] MDIO_PRE_END    = 6'd32;
    localparam logic [5:0] MDIO_CMD_END    = 6'd46;
    localparam logic [5:0] MDIO_DATA_START = 6'd48;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_XFER  = 3'd1;
    localparam logic [2:0] ST_EVAL  = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_APPLY = 3'd5;

endpackage

// File: rtl/mdio_rd_engine.sv
// rtl/mdio_rd_engine.sv - Clause-22 MDIO read master: MDC divider and PRE/CMD/TA/DATA shifter
module mdio_rd_engine
    import rgmii_link_pkg::*;
#(
    parameter int         CLK_DIV    = 25,
    parameter logic [4:0] PHY_ADDR   = 5'd0,
    parameter logic [4:0] STATUS_REG = 5'h11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_mdio,
    output logic        o_mdc,
    output logic        o_mdio,
    output logic        o_mdio_t,
    output logic        o_done,
    output logic [15:0] o_rdata
);

    localparam int            DW       = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic          r_active;
    logic          r_mdc;
    logic          r_mdio;
    logic          r_mdio_t;
    logic          r_done;
    logic [5:0]    r_bit;
    logic [DW-1:0] r_div;
    logic [15:0]   r_shift;

    logic [15:0]   w_cmd;
    logic [5:0]    w_next_bit;
    logic [5:0]    w_cmd_idx;
    logic          w_next_o;
    logic          w_next_t;

    assign w_cmd      = {2'b00, MDIO_ST, MDIO_OP_RD, PHY_ADDR, STATUS_REG};
    assign w_next_bit = r_bit + 6'd1;
    assign w_cmd_idx  = 6'd45 - w_next_bit;

    // Pad value for the bit that becomes active at the coming MDC falling edge
    always_comb begin
        w_next_o = 1'b1;
        w_next_t = 1'b1;
        if (w_next_bit < MDIO_PRE_END) begin
            w_next_t = 1'b0;
        end else if (w_next_bit < MDIO_CMD_END) begin
            w_next_o = w_cmd[w_cmd_idx[3:0]];
            w_next_t = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_mdc    <= 1'b0;
            r_mdio   <= 1'b1;
            r_mdio_t <= 1'b1;
            r_done   <= 1'b0;
            r_bit    <= 6'd0;
            r_div    <= '0;
            r_shift  <= 16'h0000;
        end else begin
            r_done <= 1'b0;
            if (!r_active) begin
                if (i_start) begin
                    r_active <= 1'b1;
                    r_bit    <= 6'd0;
                    r_div    <= '0;
                    r_mdc    <= 1'b0;
                    r_mdio   <= 1'b1;
                    r_mdio_t <= 1'b0;
                end
            end else if (r_div == DIV_LAST) begin
                r_div <= '0;
                r_mdc <= ~r_mdc;
                if (!r_mdc) begin
                    if (r_bit >= MDIO_DATA_START)
                        r_shift <= {r_shift[14:0], i_mdio};
                end else if (r_bit == MDIO_LAST_BIT) begin
                    r_active <= 1'b0;
                    r_done   <= 1'b1;
                    r_mdio   <= 1'b1;
                    r_mdio_t <= 1'b1;
                end else begin
                    r_bit    <= w_next_bit;
                    r_mdio   <= w_next_o;
                    r_mdio_t <= w_next_t;
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign o_mdc    = r_mdc;
    assign o_mdio   = r_mdio;
    assign o_mdio_t = r_mdio_t;
    assign o_done   = r_done;
    assign o_rdata  = r_shift;

endmodule

// File: rtl/rgmii_link_ctrl.sv
// rtl/rgmii_link_ctrl.sv - RGMII link/speed controller polling PHY status over MDIO
// Optional sticky link/speed interrupt when RGMII_LINK_CTRL_IRQ_EN is defined.
module rgmii_link_ctrl
    import rgmii_link_pkg::*;
#(
    parameter int         CLK_DIV     = 25,
    parameter logic [4:0] PHY_ADDR    = 5'd0,
    parameter logic [4:0] STATUS_REG  = 5'h11,
    parameter int         SPEED_MSB   = 15,
    parameter int         LINK_BIT    = 10,
    parameter int         POLL_CYCLES = 1250000,
    parameter int         HOLD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        poll_now,
    input  logic        tx_busy,
    output logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_t,
    output logic [1:0]  speed,
    output logic        link_up,
    output logic        speed_change,
    output logic        mac_rst_req,
    output logic [15:0] status_word,
    output logic        busy
`ifdef RGMII_LINK_CTRL_IRQ_EN
   ,output logic        irq,
    input  logic        irq_clr
`endif
);

    localparam logic [31:0]   POLL_LAST = 32'(POLL_CYCLES - 1);
    localparam int            HW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    logic [2:0]    r_state;
    logic [31:0]   r_poll_cnt;
    logic [HW-1:0] r_hold_cnt;
    logic          r_poll_pend;
    logic [1:0]    r_speed;
    logic [1:0]    r_new_speed;
    logic          r_link_up;
    logic          r_speed_change;
    logic          r_mac_rst_req;
    logic [15:0]   r_status;

    logic          w_start;
    logic          w_done;
    logic [15:0]   w_rdata;
    logic [1:0]    w_new_speed;
    logic          w_new_link;

    assign w_new_speed = w_rdata[SPEED_MSB -: 2];
    assign w_new_link  = w_rdata[LINK_BIT];

    always_comb begin
        w_start = 1'b0;
        case (r_state)
            ST_IDLE: w_start = enable | poll_now;
            ST_WAIT: w_start = poll_now | r_poll_pend | (enable && r_poll_cnt == POLL_LAST);
            default: w_start = 1'b0;
        endcase
    end

    mdio_rd_engine #(
        .CLK_DIV    (CLK_DIV),
        .PHY_ADDR   (PHY_ADDR),
        .STATUS_REG (STATUS_REG)
    ) u_mdio (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_mdio   (mdio_i),
        .o_mdc    (mdc),
        .o_mdio   (mdio_o),
        .o_mdio_t (mdio_t),
        .o_done   (w_done),
        .o_rdata  (w_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_poll_cnt     <= 32'd0;
            r_hold_cnt     <= '0;
            r_poll_pend    <= 1'b0;
            r_speed        <= SPEED_1000M;
            r_new_speed    <= SPEED_1000M;
            r_link_up      <= 1'b0;
            r_speed_change <= 1'b0;
            r_mac_rst_req  <= 1'b0;
            r_status       <= 16'h0000;
        end else begin
            r_speed_change <= 1'b0;
            // A poll request arriving while a transaction is in flight is replayed once on WAIT entry
            if (w_start)
                r_poll_pend <= 1'b0;
            else if (poll_now && r_state != ST_IDLE && r_state != ST_WAIT)
                r_poll_pend <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (w_start)
                        r_state <= ST_XFER;
                end
                ST_XFER: begin
                    if (w_done)
                        r_state <= ST_EVAL;
                end
                ST_EVAL: begin
                    r_status   <= w_rdata;
                    r_link_up  <= w_new_link;
                    r_poll_cnt <= 32'd0;
                    if (w_new_link && w_new_speed != SPEED_RSVD && w_new_speed != r_speed) begin
                        r_new_speed <= w_new_speed;
                        r_state     <= ST_DRAIN;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_DRAIN: begin
                    if (!tx_busy) begin
                        r_speed        <= r_new_speed;
                        r_speed_change <= 1'b1;
                        r_mac_rst_req  <= 1'b1;
                        r_hold_cnt     <= HOLD_LAST;
                        r_state        <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    if (r_hold_cnt == '0) begin
                        r_mac_rst_req <= 1'b0;
                        r_poll_cnt    <= 32'd0;
                        r_state       <= ST_WAIT;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (w_start)
                        r_state <= ST_XFER;
                    else if (!enable)
                        r_state <= ST_IDLE;
                    else
                        r_poll_cnt <= r_poll_cnt + 32'd1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef RGMII_LINK_CTRL_IRQ_EN
    logic r_irq;
    logic r_link_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq    <= 1'b0;
            r_link_d <= 1'b0;
        end else begin
            r_link_d <= r_link_up;
            if ((r_link_up != r_link_d) || r_speed_change)
                r_irq <= 1'b1;
            else if (irq_clr)
                r_irq <= 1'b0;
        end
    end

    assign irq = r_irq;
`endif

    assign speed        = r_speed;
    assign link_up      = r_link_up;
    assign speed_change = r_speed_change;
    assign mac_rst_req  = r_mac_rst_req;
    assign status_word  = r_status;
    assign busy         = (r_state != ST_IDLE) && (r_state != ST_WAIT);

endmodule
